// File: rtl/mix_columns_stream_if.sv
// Byte streams for the MixColumns engine: an input stream of state bytes and
// an output stream of result bytes, each with its own valid/ready handshake.
interface mix_columns_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  // Producer/consumer side (drives input bytes, accepts output bytes).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Engine side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mix_columns_stream.sv
// Byte-serial AES MixColumns / InvMixColumns engine. Loads a 16-byte state one
// byte per cycle, transforms it in place one column per cycle, then drains the
// 16 result bytes. Direction is latched with the first byte of each block.
module mix_columns_stream (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ed,
  output logic                 busy,
  mix_columns_stream_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MIX   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [127:0] state_buf;
  logic [3:0]   cnt;
  logic [1:0]   col;
  logic         ed_r;
  logic         in_fire;
  logic         out_fire;
  logic [31:0]  col_mixed;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Transform one column; byte r of the word (bits 8r+:8) is row r.
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic enc);
    logic [7:0]  b  [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m3 [4];
    logic [7:0]  m9 [4];
    logic [7:0]  m11[4];
    logic [7:0]  m13[4];
    logic [7:0]  m14[4];
    logic [7:0]  x4;
    logic [7:0]  x8;
    logic [31:0] res;
    res = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b[i]   = c[8*i +: 8];
      m2[i]  = xtime(b[i]);
      x4     = xtime(m2[i]);
      x8     = xtime(x4);
      m3[i]  = m2[i] ^ b[i];
      m9[i]  = x8 ^ b[i];
      m11[i] = x8 ^ m2[i] ^ b[i];
      m13[i] = x8 ^ x4 ^ b[i];
      m14[i] = x8 ^ x4 ^ m2[i];
    end
    for (int r = 0; r < 4; r++) begin
      if (enc)
        res[8*r +: 8] = m2[r] ^ m3[(r+1)%4] ^ b[(r+2)%4] ^ b[(r+3)%4];
      else
        res[8*r +: 8] = m14[r] ^ m11[(r+1)%4] ^ m13[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  assign in_fire   = bus.in_valid && (state == LOAD);
  assign out_fire  = bus.out_ready && (state == DRAIN);
  assign col_mixed = mix_col(state_buf[{col, 5'b00000} +: 32], ed_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_next;
  end

  // Next-state decode: load 16 bytes, mix 4 columns, drain 16 bytes.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_fire && cnt == 4'd15) state_next = MIX;
      MIX:     if (col == 2'd3)             state_next = DRAIN;
      DRAIN:   if (out_fire && cnt == 4'd15) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Stream outputs decoded from registered state only.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    bus.out_last  = 1'b0;
    case (state)
      LOAD:  bus.in_ready = 1'b1;
      DRAIN: begin
        bus.out_valid = 1'b1;
        bus.out_data  = state_buf[{cnt, 3'b000} +: 8];
        bus.out_last  = (cnt == 4'd15);
      end
      default: ;
    endcase
  end

  // Buffer, counters, latched direction and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_buf <= 128'h0;
      cnt       <= 4'd0;
      col       <= 2'd0;
      ed_r      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: if (in_fire) begin
          state_buf[{cnt, 3'b000} +: 8] <= bus.in_data;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd0) begin
            ed_r <= ed;
            busy <= 1'b1;
          end
        end
        MIX: begin
          state_buf[{col, 5'b00000} +: 32] <= col_mixed;
          col <= col + 2'd1;
        end
        DRAIN: if (out_fire) begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_stream.sv
// Bench for mix_columns_stream: a GF(2^8) matrix model predicts every result
// byte from the captured input bytes; one compare process checks the output
// stream every cycle, plus directed AES vectors, resets and back-to-back runs.
module tb_mix_columns_stream;

  logic clk = 1'b0;
  logic rst_n;
  logic ed;
  logic busy;
  mix_columns_stream_if bus ();

  mix_columns_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ed    (ed),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit rr_mode  = 1'b0;  // random out_ready
  bit b2b_mode = 1'b0;  // check 36-cycle block spacing

  logic [7:0] s1_in [16] = '{8'hdb, 8'h13, 8'h53, 8'h45, 8'hf2, 8'h0a, 8'h22, 8'h5c,
                             8'h01, 8'h01, 8'h01, 8'h01, 8'h2d, 8'h26, 8'h31, 8'h4c};
  logic [7:0] s1_out[16] = '{8'h8e, 8'h4d, 8'ha1, 8'hbc, 8'h9f, 8'hdc, 8'h58, 8'h9d,
                             8'h01, 8'h01, 8'h01, 8'h01, 8'h4d, 8'h7e, 8'hbd, 8'hf8};

  // Compare process state
  logic [7:0] cap[16];
  logic [7:0] out_log[16];
  logic [7:0] exp_q[$];
  logic       cap_ed;
  int         in_cnt = 0;
  int         out_idx = 0;
  int         last_in_edge = 0;
  int         first_edge = 0;
  bit         have_prev = 1'b0;
  bit         lat_armed = 1'b0;
  bit         held = 1'b0;
  bit         turn_pend = 1'b0;
  logic [7:0] held_data;
  logic       held_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rr_mode ? 1'($urandom_range(1)) : 1'b1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Carry-less multiply then reduce by the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 11; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // State-level MixColumns: row r, column j coefficient is base[(j-r) mod 4].
  function automatic void model(input logic [7:0] blk[16], input logic enc,
                                output logic [7:0] res[16]);
    int base[4];
    logic [7:0] acc;
    if (enc) base = '{2, 3, 1, 1};
    else     base = '{14, 11, 13, 9};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(blk[4*c + j], base[(j - r + 4) % 4]);
        res[4*c + r] = acc;
      end
  endfunction

  function automatic logic [127:0] pack(input logic [7:0] blk[16]);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[8*k +: 8] = blk[k];
    return v;
  endfunction

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] res[16];
    if (!rst_n) begin
      in_cnt = 0; out_idx = 0; exp_q.delete();
      held = 1'b0; turn_pend = 1'b0; lat_armed = 1'b0; have_prev = 1'b0;
    end else begin
      if (turn_pend) begin
        check("turnaround_in_ready", 128'(bus.in_ready), 128'(1'b1));
        turn_pend = 1'b0;
      end
      if (!b2b_mode) have_prev = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        if (in_cnt == 0) begin
          cap_ed = ed;
          if (have_prev) check("block_period", 128'(cyc + 1 - first_edge), 128'(36));
          first_edge = cyc + 1;
          have_prev  = b2b_mode;
        end
        cap[in_cnt] = bus.in_data;
        in_cnt++;
        if (in_cnt == 16) begin
          in_cnt = 0;
          model(cap, cap_ed, res);
          for (int k = 0; k < 16; k++) exp_q.push_back(res[k]);
          last_in_edge = cyc + 1;
          lat_armed = 1'b1;
        end
      end
      if (bus.out_valid) begin
        check("in_ready_drain", 128'(bus.in_ready), 128'(1'b0));
        check("busy_drain", 128'(busy), 128'(1'b1));
        if (lat_armed) begin
          check("first_out_latency", 128'(cyc + 1 - last_in_edge), 128'(5));
          lat_armed = 1'b0;
        end
        if (held) begin
          check("stall_stable", 128'({bus.out_data, bus.out_last}), 128'({held_data, held_last}));
        end
        if (exp_q.size() == 0) begin
          check("unexpected_out", 128'(bus.out_valid), 128'(1'b0));
        end else begin
          check("out_data", 128'(bus.out_data), 128'(exp_q[0]));
          check("out_last", 128'(bus.out_last), 128'(out_idx == 15));
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          out_log[out_idx] = bus.out_data;
          if (out_idx == 15) turn_pend = 1'b1;
          out_idx = (out_idx + 1) % 16;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_data = bus.out_data;
          held_last = bus.out_last;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic send_block(input logic [7:0] blk[16], input logic e, input int gap_pct,
                            input bit flip);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    while (k < 16 && guard < 4000) begin
      bus.in_data  = blk[k];
      bus.in_valid = ($urandom_range(99) >= gap_pct);
      if (k == 0) ed = e;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        if (flip && k == 1) ed = ~e;
      end
      guard++;
    end
    bus.in_valid = 1'b0;
    if (guard >= 4000) check("send_timeout", 128'(k), 128'(16));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) check("drain_timeout", 128'(busy), 128'(1'b0));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_block(output logic [7:0] blk[16]);
    for (int k = 0; k < 16; k++) blk[k] = 8'($urandom_range(255));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] res[16];
    logic [7:0] blk[16];
    logic [7:0] c6[16];
    int n;
    for (int k = 0; k < 16; k++) c6[k] = 8'hc6;
    rst_n = 1'b0;
    ed = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    #15;
    check("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
    check("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("reset_out_data", 128'(bus.out_data), 128'(8'h00));
    check("reset_out_last", 128'(bus.out_last), 128'(1'b0));
    check("reset_busy", 128'(busy), 128'(1'b0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Pin the model to the known AES vectors.
    model(s1_in, 1'b1, res);
    check("model_enc", pack(res), pack(s1_out));
    model(s1_out, 1'b0, res);
    check("model_dec", pack(res), pack(s1_in));
    model(c6, 1'b0, res);
    check("model_c6", pack(res), pack(c6));

    // Directed encrypt / decrypt.
    @(posedge clk); #1;
    send_block(s1_in, 1'b1, 0, 1'b0);
    wait_drain();
    check("enc_vector", pack(out_log), pack(s1_out));
    send_block(s1_out, 1'b0, 0, 1'b0);
    wait_drain();
    check("dec_vector", pack(out_log), pack(s1_in));
    send_block(c6, 1'b0, 0, 1'b0);
    wait_drain();
    check("dec_c6", pack(out_log), pack(c6));

    // Gapped input, ed flipped after byte 0.
    send_block(s1_in, 1'b1, 50, 1'b1);
    wait_drain();
    check("gapped_ed_flip", pack(out_log), pack(s1_out));

    // Random blocks with random gaps and backpressure.
    rr_mode = 1'b1;
    for (int b = 0; b < 6; b++) begin
      rand_block(blk);
      send_block(blk, 1'($urandom_range(1)), 40, 1'($urandom_range(1)));
      wait_drain();
    end

    // Reset during MIX.
    rr_mode = 1'b0;
    rand_block(blk);
    send_block(blk, 1'b1, 0, 1'b0);
    @(posedge clk);
    #2;
    pulse_reset();
    send_block(s1_in, 1'b1, 0, 1'b0);
    wait_drain();
    check("after_mix_reset", pack(out_log), pack(s1_out));

    // Reset during DRAIN byte 7.
    rand_block(blk);
    send_block(blk, 1'b0, 0, 1'b0);
    n = 0;
    while (out_idx != 7 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_drain_byte7", 128'(out_idx), 128'(7));
    #1;
    pulse_reset();
    send_block(s1_out, 1'b0, 0, 1'b0);
    wait_drain();
    check("after_drain_reset", pack(out_log), pack(s1_in));

    // Three back-to-back blocks, in_valid and out_ready high throughout.
    b2b_mode = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rand_block(blk);
      send_block(blk, 1'($urandom_range(1)), 0, 1'b0);
    end
    wait_drain();
    b2b_mode = 1'b0;
    check("b2b_idle", 128'(busy), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_stream.md
# mix_columns_stream

Byte-serial AES MixColumns / InvMixColumns engine for the cipher datapath. It receives a 16-byte state one byte per cycle over a valid/ready stream and buffers it. It transforms the four columns one per cycle and returns the 16 result bytes over a second valid/ready stream. It is the streaming front/back end that lets byte-wide producers and consumers (I/O, key-add, S-box stages) use the column transform, in either cipher direction, selected per block.

## Interface
- No parameters. Data width is fixed at 8 bits and block size at 16 bytes.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ed  input  1  direction: 1 = MixColumns (encrypt), 0 = InvMixColumns (decrypt). Sampled with the first byte of each block.
- in_valid  input  1  in_data holds a valid byte.
- in_ready  output  1  the block accepts a byte this cycle.
- in_data  input  8  state byte, AES column-major order: byte k is row k%4 of column k/4.
- out_valid  output  1  out_data holds a valid result byte.
- out_ready  input  1  the consumer accepts out_data this cycle.
- out_data  output  8  result byte, same ordering as the input.
- out_last  output  1  high with the 16th result byte.
- busy  output  1  high from the first accepted byte until the 16th output handshake.

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge.
- Storage: a 128-bit state buffer, a 4-bit byte counter and a 2-bit column counter.
- State machine, reset state LOAD:
  - LOAD:
    - in_ready = 1.
    - Each input transfer writes byte [cnt] and increments cnt.
    - The transfer with cnt = 0 also latches ed into ed_r and sets busy.
    - The transfer with cnt = 15 moves to MIX, with cnt and col at 0.
  - MIX: four cycles.
    - Each cycle replaces column col in place with its transform, then increments col.
    - After col = 3, moves to DRAIN.
    - in_ready = 0 and out_valid = 0 throughout.
  - DRAIN:
    - out_valid = 1 and out_data = byte [cnt].
    - Each output transfer increments cnt.
    - out_last = (cnt == 15).
    - The transfer with cnt = 15 returns to LOAD, clears cnt and clears busy.
- Column transform, with column bytes b0..b3 = rows 0..3 and all arithmetic in GF(2^8) mod x^8+x^4+x^3+x+1:
  - xtime(a) = {a[6:0],0} ^ (8'h1b if a[7]).
  - ed_r = 1 uses matrix rows (2 3 1 1), (1 2 3 1), (1 1 2 3), (3 1 1 2).
  - ed_r = 0 uses matrix rows (14 11 13 9), (9 14 11 13), (13 9 14 11), (11 13 9 14).
- Changes to ed after the first byte of a block have no effect on that block.
- in_valid may drop between bytes. The counter holds, and nothing is lost or duplicated.
- No overlap: a new block is not accepted until the previous block has fully drained.

## Timing
- Reset values:
  - State is LOAD, cnt = 0, col = 0, ed_r = 0, buffer = 0.
  - in_ready = 1, out_valid = 0, out_data = 8'h00, out_last = 0, busy = 0.
- Reset is asynchronous. Asserting rst_n low at any point, including mid-LOAD, MIX or DRAIN, immediately forces the reset values and discards the partial block.
- Latency:
  - The 16th input transfer happens at edge T.
  - MIX occupies edges T+1..T+4.
  - out_valid rises after edge T+4 and the first byte is presentable at T+5.
- Throughput: 16 + 4 + 16 = 36 cycles per block with no stalls.
- Backpressure: while out_valid = 1 and out_ready = 0, out_data and out_last stay stable.
- Turnaround: in_ready rises in the cycle after the 16th output transfer, so the new block's first byte can be accepted at the next edge.
- Outputs out_valid, out_data, out_last and busy are registered or decoded only from registered state. There is no combinational path from the inputs to any output.

## Test plan
- Encrypt, ed = 1:
  - Input: db 13 53 45 | f2 0a 22 5c | 01 01 01 01 | 2d 26 31 4c.
  - Required output: 8e 4d a1 bc | 9f dc 58 9d | 01 01 01 01 | 4d 7e bd f8.
  - out_last is high only on f8, and the first out_valid appears 5 cycles after the last input transfer.
- Decrypt, ed = 0: feed the scenario-1 output and require the scenario-1 input back byte-exact. Also require c6 c6 c6 c6 -> c6 c6 c6 c6.
- Gapped input with ed toggling:
  - in_valid is random at roughly 50%, and ed is flipped after the first byte.
  - The result must equal the scenario-1 output, i.e. the direction latched at byte 0 is used.
- Output backpressure:
  - out_ready is random.
  - out_data and out_last must be stable across every stall, the byte order must be exact, and in_ready must stay 0 for the whole drain.
- Reset mid-block:
  - Pulse rst_n low during MIX cycle 2, and again during DRAIN byte 7.
  - out_valid and busy must drop without waiting for a clock edge, and in_ready must be 1 after release.
  - The next full block must produce correct results.
- Back-to-back blocks:
  - Run three blocks with in_valid and out_ready tied high.
  - Every block must take 36 cycles, each block's in_ready must rise the cycle after the previous block's out_last handshake, and all results must be correct.
